// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory with a valid/ready request-response handshake (IDLE->BUSY->RESP).
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned accesses into error responses.
module data_mem_ctrl #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0]     DEPTH_U = 32'(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  function automatic logic [ADDR_W-1:0] reduce_addr(input logic [ADDR_W-1:0] a);
    logic [31:0] t;
    t = 32'(a) % DEPTH_U;
    return t[ADDR_W-1:0];
  endfunction

  // Operand is already < DEPTH and offset < 8, so a single subtraction wraps it.
  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] a, input logic [2:0] off);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {{(ADDR_W-2){1'b0}}, off};
    if (s >= DEPTH_W) begin
      s = s - DEPTH_W;
    end
    return s[ADDR_W-1:0];
  endfunction

  state_e            state_q, state_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [63:0]       rdata_q;
  logic              err_q;

  logic [7:0]        mem_q [DEPTH];

  logic [ADDR_W-1:0] byte_addr_s [8];
  logic [63:0]       raw_s;
  logic [7:0]        byte_en_s;
  logic [63:0]       load_s;
  logic [63:0]       resp_data_s;
  logic              illegal_s;
  logic              misalign_s;
  logic              err_s;
  logic              wr_en_s;
  logic              accept_s;

  assign accept_s  = (state_q == IDLE) & req_valid;
  assign illegal_s = we_q ? funct3_q[2] : (funct3_q == 3'b111);
  assign err_s     = illegal_s | misalign_s;
  assign wr_en_s   = (state_q == BUSY) & we_q & ~err_s;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic [2:0] align_mask_s;

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   align_mask_s = 3'b000;
      2'b01:   align_mask_s = 3'b001;
      2'b10:   align_mask_s = 3'b011;
      default: align_mask_s = 3'b111;
    endcase
  end

  assign misalign_s = |(addr_q[2:0] & align_mask_s);
`else
  assign misalign_s = 1'b0;
`endif

  always_comb begin
    raw_s = 64'h0;
    for (int i = 0; i < 8; i++) begin
      byte_addr_s[i]   = wrap_add(addr_q, 3'(i));
      raw_s[8*i +: 8]  = mem_q[byte_addr_s[i]];
    end
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   byte_en_s = 8'h01;
      2'b01:   byte_en_s = 8'h03;
      2'b10:   byte_en_s = 8'h0F;
      default: byte_en_s = 8'hFF;
    endcase
  end

  always_comb begin
    case (funct3_q)
      3'b000:  load_s = {{56{raw_s[7]}},  raw_s[7:0]};
      3'b001:  load_s = {{48{raw_s[15]}}, raw_s[15:0]};
      3'b010:  load_s = {{32{raw_s[31]}}, raw_s[31:0]};
      3'b011:  load_s = raw_s;
      3'b100:  load_s = {56'h0, raw_s[7:0]};
      3'b101:  load_s = {48'h0, raw_s[15:0]};
      3'b110:  load_s = {32'h0, raw_s[31:0]};
      default: load_s = 64'h0;
    endcase
  end

  always_comb begin
    if (we_q || err_s) begin
      resp_data_s = 64'h0;
    end else begin
      resp_data_s = load_s;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: state_d = RESP;
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 64'h0;
      rdata_q  <= 64'h0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_s) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= reduce_addr(req_addr);
        wdata_q  <= req_wdata;
      end
      if (state_q == BUSY) begin
        rdata_q <= resp_data_s;
        err_q   <= err_s;
      end
    end
  end

  // Storage is never reset; the write is suppressed on a reset edge.
  always_ff @(posedge clk) begin
    if (!rst && wr_en_s) begin
      for (int i = 0; i < 8; i++) begin
        if (byte_en_s[i]) begin
          mem_q[byte_addr_s[i]] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl; expectations come from a byte-array reference model.
// Define DMEM_MISALIGN_TRAP_EN for both DUT and bench to check the trap build.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [12:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mdl [8192];

  data_mem_ctrl #(.ADDR_W(13), .DEPTH(8192)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [12:0] addr);
    logic bad;
    int   nb;
    bad = we ? f3[2] : (f3 == 3'b111);
    nb  = 1 << f3[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((int'(addr) % nb) != 0) bad = 1'b1;
`else
    if (nb < 0) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [12:0] addr);
    logic [63:0] raw;
    raw = 64'h0;
    for (int i = 0; i < (1 << f3[1:0]); i++) raw[8*i +: 8] = mdl[(int'(addr) + i) % 8192];
    case (f3)
      3'b000:  return {{56{raw[7]}}, raw[7:0]};
      3'b001:  return {{48{raw[15]}}, raw[15:0]};
      3'b010:  return {{32{raw[31]}}, raw[31:0]};
      3'b011:  return raw;
      3'b100:  return {56'h0, raw[7:0]};
      3'b101:  return {48'h0, raw[15:0]};
      3'b110:  return {32'h0, raw[31:0]};
      default: return 64'h0;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [12:0] addr, input logic [63:0] wd);
    for (int i = 0; i < (1 << f3[1:0]); i++) mdl[(int'(addr) + i) % 8192] = wd[8*i +: 8];
  endtask

  // Full transaction; has_exp overrides the model's rdata with a fixed constant.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [12:0] addr, input logic [63:0] wd,
                        input logic has_exp, input logic [63:0] exp_rd);
    exp_t e;
    int   n;
    e.err   = model_err(we, f3, addr);
    e.rdata = (we || e.err) ? 64'h0 : (has_exp ? exp_rd : model_load(f3, addr));
    if (we && !e.err) model_store(f3, addr, wd);
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, ":ready"}, 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    check({tag, ":valid"}, 64'(resp_valid), 64'h1);
    e = sb_q.pop_front();
    check({tag, ":rdata"}, resp_rdata, e.rdata);
    check({tag, ":err"}, 64'(resp_err), 64'(e.err));
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] held;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 13'h0; req_wdata = 64'h0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst:req_ready", 64'(req_ready), 64'h1);
    check("rst:resp_valid", 64'(resp_valid), 64'h0);
    check("rst:rdata", resp_rdata, 64'h0);
    check("rst:err", 64'(resp_err), 64'h0);

    // Basic store and sized/signed loads
    do_req("sd010", 1'b1, 3'b011, 13'h010, 64'h8877665544332211, 1'b0, 64'h0);
    do_req("ld010", 1'b0, 3'b011, 13'h010, 64'h0, 1'b1, 64'h8877665544332211);
    do_req("lb017", 1'b0, 3'b000, 13'h017, 64'h0, 1'b1, 64'hFFFFFFFFFFFFFF88);
    do_req("lbu017", 1'b0, 3'b100, 13'h017, 64'h0, 1'b1, 64'h0000000000000088);
    do_req("lw014", 1'b0, 3'b010, 13'h014, 64'h0, 1'b1, 64'hFFFFFFFF88776655);
    do_req("lwu014", 1'b0, 3'b110, 13'h014, 64'h0, 1'b0, 64'h0);
    do_req("lh016", 1'b0, 3'b001, 13'h016, 64'h0, 1'b0, 64'h0);
    do_req("lhu016", 1'b0, 3'b101, 13'h016, 64'h0, 1'b0, 64'h0);

    // Latency and response hold under back-pressure
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 13'h010;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("lat:busy_valid", 64'(resp_valid), 64'h0);
    check("lat:busy_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    check("lat:valid", 64'(resp_valid), 64'h1);
    held = model_load(3'b011, 13'h010);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hold:valid", 64'(resp_valid), 64'h1);
      check("hold:rdata", resp_rdata, held);
      check("hold:err", 64'(resp_err), 64'h0);
      check("hold:req_ready", 64'(req_ready), 64'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    @(negedge clk);
    check("hold:released", 64'(resp_valid), 64'h0);
    check("hold:idle", 64'(req_ready), 64'h1);

    // Illegal funct3
    do_req("sw110", 1'b1, 3'b110, 13'h010, 64'hDEADBEEFCAFEF00D, 1'b0, 64'h0);
    do_req("ld_after_ill", 1'b0, 3'b011, 13'h010, 64'h0, 1'b0, 64'h0);
    do_req("ld111", 1'b0, 3'b111, 13'h010, 64'h0, 1'b0, 64'h0);

    // Wrap at top of memory
    do_req("pre1FFF", 1'b1, 3'b000, 13'h1FFF, 64'h33, 1'b0, 64'h0);
    do_req("pre0000", 1'b1, 3'b000, 13'h0000, 64'h44, 1'b0, 64'h0);
    do_req("sh1FFF", 1'b1, 3'b001, 13'h1FFF, 64'hBBAA, 1'b0, 64'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    do_req("lbu1FFF", 1'b0, 3'b100, 13'h1FFF, 64'h0, 1'b1, 64'h33);
    do_req("lbu0000", 1'b0, 3'b100, 13'h0000, 64'h0, 1'b1, 64'h44);
`else
    do_req("lbu1FFF", 1'b0, 3'b100, 13'h1FFF, 64'h0, 1'b1, 64'hAA);
    do_req("lbu0000", 1'b0, 3'b100, 13'h0000, 64'h0, 1'b1, 64'hBB);
`endif
    do_req("lw013", 1'b0, 3'b010, 13'h013, 64'h0, 1'b0, 64'h0);

    // Reset while a store sits in BUSY
    do_req("pre020", 1'b1, 3'b000, 13'h020, 64'h11, 1'b0, 64'h0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 13'h020; req_wdata = 64'h5A;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rstbusy:valid", 64'(resp_valid), 64'h0);
    check("rstbusy:ready", 64'(req_ready), 64'h1);
    do_req("lbu020", 1'b0, 3'b100, 13'h020, 64'h0, 1'b1, 64'h11);

    // Random region fill and mixed loads
    for (int a = 13'h100; a < 13'h180; a += 8)
      do_req("rnd_sd", 1'b1, 3'b011, 13'(a), {$urandom, $urandom}, 1'b0, 64'h0);
    for (int k = 0; k < 16; k++) begin
      logic [2:0] f3;
      f3 = 3'($urandom_range(0, 6));
      do_req("rnd_ld", 1'b0, f3, 13'($urandom_range(13'h100, 13'h178)), 64'h0, 1'b0, 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
